// File: rtl/bus_valid_delay_if.sv
// Valid/ready/data bus bundle seen by bus_valid_delay: upstream (_i valid/data, ready_o)
// and downstream (valid_o/data_o, ready_i). slave = the slice, master = the surrounding logic.
interface bus_valid_delay_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/bus_valid_delay.sv
// Forward-registered valid/data pipeline slice with combinational ready and bubble collapse.
// Optional macro BUS_VALID_DELAY_CLR_DATA_EN: zero a stage's data whenever it goes invalid.
module bus_valid_delay #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  localparam int CW     = $clog2(STAGES+1)
) (
  input  logic          clk,
  input  logic          rst,
  bus_valid_delay_if.slave b,
  input  logic          flush_i,
  output logic [CW-1:0] count_o
);

  logic [STAGES-1:0]            v, r, vin;
  logic [STAGES-1:0][WIDTH-1:0] d, din;
  logic                         acc, in_fire, out_fire;

  // A stage can load if any stage at or after it is empty, or the consumer takes the head.
  always_comb begin
    r   = '0;
    acc = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      acc = b.ready_i;
      for (int j = k; j < STAGES; j++) acc = acc | ~v[j];
      r[k] = acc;
    end
  end

  assign b.ready_o = r[0] & ~flush_i & ~rst;
  assign in_fire   = b.valid_i & b.ready_o;
  assign out_fire  = v[STAGES-1] & b.ready_i;
  assign b.valid_o = v[STAGES-1];
  assign b.data_o  = d[STAGES-1];

  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = in_fire;
    din[0] = b.data_i;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = v[k-1];
      din[k] = d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v       <= '0;
      d       <= '0;
      count_o <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush_i)   v[k] <= 1'b0;
        else if (r[k]) v[k] <= vin[k];
`ifdef BUS_VALID_DELAY_CLR_DATA_EN
        if (flush_i || (r[k] && !vin[k])) d[k] <= '0;
        else if (r[k])                    d[k] <= din[k];
`else
        if (r[k] && vin[k]) d[k] <= din[k];
`endif
      end
      if (flush_i) count_o <= '0;
      else         count_o <= count_o + CW'(in_fire) - CW'(out_fire);
    end
  end

endmodule

// File: tb/tb_bus_valid_delay.sv
// Randomized + directed bench for bus_valid_delay against a queue-of-beats position model.
module tb_bus_valid_delay;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int CW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  int            total = 0;
  int            bad   = 0;

  // model: beats oldest-first, each with its distance travelled (0 = first stage, S-1 = output)
  logic [W-1:0] mq[$];
  int           mp[$];

  always #5 clk = ~clk;

  bus_valid_delay_if #(.WIDTH(W)) b();

  bus_valid_delay #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .b(b), .flush_i(flush), .count_o(count)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !rst && !flush && (b.ready_i || mq.size() < S);
  endfunction

  function automatic logic m_valid();
    return mq.size() > 0 && mp[0] == S-1;
  endfunction

  task automatic cmp();
    chk("ready_o", W'(b.ready_o), W'(m_ready()));
    chk("valid_o", W'(b.valid_o), W'(m_valid()));
    chk("count_o", W'(count), W'(mq.size()));
    if (m_valid()) chk("data_o", b.data_o, mq[0]);
`ifdef BUS_VALID_DELAY_CLR_DATA_EN
    else chk("data_o_clr", b.data_o, '0);
`endif
  endtask

  task automatic drive(input logic vi, input logic [W-1:0] di, input logic ri,
                       input logic fl, input logic rs);
    b.valid_i = vi; b.data_i = di; b.ready_i = ri; flush = fl; rst = rs;
    #1;
    cmp();
  endtask

  task automatic model_update();
    logic [W-1:0] nq[$];
    int           np[$];
    logic         rdy, outf, inf;
    if (rst) begin
      mq.delete(); mp.delete();
    end else begin
      rdy  = m_ready();
      outf = m_valid() && b.ready_i;
      inf  = b.valid_i && rdy;
      if (!flush) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (j == 0 && outf) continue;
          nq.push_back(mq[j]);
          // a beat stops only when packed solid against a stalled output
          np.push_back((!b.ready_i && mp[j] == S-1-j) ? mp[j] : mp[j] + 1);
        end
        if (inf) begin
          nq.push_back(b.data_i); np.push_back(0);
        end
      end
      mq = nq; mp = np;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    b.valid_i = 1'b0; b.data_i = '0; b.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // reset
    drive(0, 0, 1, 0, 1); chk("ready_in_rst", W'(b.ready_o), 0); tick();
    drive(0, 0, 1, 0, 1); tick();
    drive(0, 0, 1, 0, 0);
    chk("rst_valid", W'(b.valid_o), 0); chk("rst_data", b.data_o, 0);
    chk("rst_count", W'(count), 0);     chk("rst_ready", W'(b.ready_o), 1);
    tick();

    // streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1, W'(i), 1, 0, 0);
      chk("stream_ready", W'(b.ready_o), 1);
      if (i == 2) chk("stream_latency", W'(b.valid_o), 0);
      if (i >= 3) begin
        chk("stream_data", b.data_o, W'(i-2));
        chk("stream_count", W'(count), 2);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); tick(); end

    // backpressure
    drive(1, 32'hA, 0, 0, 0); tick();
    drive(1, 32'hB, 0, 0, 0); tick();
    drive(1, 32'hC, 0, 0, 0);
    chk("bp_ready", W'(b.ready_o), 0); chk("bp_count", W'(count), 2);
    chk("bp_data", b.data_o, 32'hA);
    tick();
    drive(1, 32'hC, 0, 0, 0); chk("bp_hold", b.data_o, 32'hA); tick();
    drive(1, 32'hC, 1, 0, 0); chk("bp_out0", b.data_o, 32'hA); tick();
    drive(0, 0, 1, 0, 0);     chk("bp_out1", b.data_o, 32'hB); tick();
    drive(0, 0, 1, 0, 0);     chk("bp_out2", b.data_o, 32'hC); tick();
    drive(0, 0, 1, 0, 0);     chk("bp_empty", W'(count), 0);   tick();

    // bubble collapse
    drive(1, 32'h5, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); chk("bub_count", W'(count), 1); chk("bub_v0", W'(b.valid_o), 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("bub_valid", W'(b.valid_o), 1); chk("bub_data", b.data_o, 32'h5);
    chk("bub_ready", W'(b.ready_o), 1);
    tick();
    drive(1, 32'h6, 0, 0, 0); chk("bub_acc", W'(b.ready_o), 1); tick();
    drive(0, 0, 0, 0, 0); chk("bub_full", W'(count), 2); chk("bub_rdy0", W'(b.ready_o), 0); tick();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); tick(); end

    // flush
    drive(1, 32'hA, 0, 0, 0); tick();
    drive(1, 32'hB, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0);
    chk("fl_data", b.data_o, 32'hA); chk("fl_valid", W'(b.valid_o), 1);
    chk("fl_ready", W'(b.ready_o), 0);
    tick();
    drive(0, 0, 1, 0, 0);
    chk("fl_after_valid", W'(b.valid_o), 0); chk("fl_after_count", W'(count), 0);
`ifdef BUS_VALID_DELAY_CLR_DATA_EN
    chk("fl_clr_data", b.data_o, 0);
`else
    chk("fl_stale_data", b.data_o, 32'hB);
`endif
    tick();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); tick(); end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 70), $urandom, ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
